// File: rtl/vec_mag_pkg.sv
// vec_mag_pkg: shared types and constants for the vector-magnitude pipeline.
// Holds the coordinate width default, the packed-word width, the lane index
// type and the bit offsets of each lane inside the packed word.
package vec_mag_pkg;

   localparam int COORD_WIDTH = 8;

   function automatic int axis_tdata_width(input int cw);
      return 4 * cw;
   endfunction

   localparam int AXIS_TDATA_WIDTH = 4 * COORD_WIDTH;

   typedef enum logic [1:0] {
      LANE_X1 = 2'd0,
      LANE_Y1 = 2'd1,
      LANE_X2 = 2'd2,
      LANE_Y2 = 2'd3
   } lane_t;

   // LSB position of each lane in the packed word {x1, y1, x2, y2}
   localparam int LANE_X1_LSB = 3 * COORD_WIDTH;
   localparam int LANE_Y1_LSB = 2 * COORD_WIDTH;
   localparam int LANE_X2_LSB = 1 * COORD_WIDTH;
   localparam int LANE_Y2_LSB = 0;

endpackage

// File: rtl/vec_mag_packer_if.sv
// vec_mag_packer_if: AXI-Stream bundle (data, valid, last, ready).
// Handshake: a beat transfers on a rising aclk edge where tvalid && tready;
// the master holds tdata/tlast stable while tvalid && !tready and never
// withdraws tvalid before the transfer.
interface vec_mag_packer_if #(
   parameter int W = 8
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tlast;
   logic         tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/vec_pack_out_reg.sv
// vec_pack_out_reg: single-entry AXIS output register slice.
// Loads a word when load is asserted, holds it until the consumer takes it,
// and allows a load in the same cycle as a drain for seamless hand-over.
module vec_pack_out_reg #(
   parameter int W = 32
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         load_last,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         can_load
);

   // A new word may enter when the slot is empty or being drained this cycle
   assign can_load = !out_valid || out_ready;

   // Valid/data/last hold: reload wins over drain, data only changes on load
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_last  <= load_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/vec_mag_packer.sv
// vec_mag_packer: packs four narrow AXIS coordinate beats (x1, y1, x2, y2)
// into one wide AXIS word {x1, y1, x2, y2} for the magnitude core.
// Optional macro VEC_PACK_TLAST_CHECK_EN: an early tlast (on x1, y1 or x2)
// discards the partial group and pulses frame_err for one cycle; without it
// early tlast is ignored and frame_err is tied low.
module vec_mag_packer
   import vec_mag_pkg::*;
#(
   parameter int COORD_WIDTH = vec_mag_pkg::COORD_WIDTH
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   vec_mag_packer_if.slave         s_axis,
   vec_mag_packer_if.master        m_axis,
   output logic                    frame_err
);

   localparam int CW = COORD_WIDTH;
   localparam int TW = axis_tdata_width(COORD_WIDTH);

   lane_t             lane;
   logic [3*CW-1:0]   collect;
   logic              accept;
   logic              load;
   logic              can_load;
   logic              early_last;

   // Only the y2 beat depends on the output slot; x1..x2 always flow
   assign s_axis.tready = aresetn && ((lane != LANE_Y2) || can_load);
   assign accept        = s_axis.tvalid && s_axis.tready;
   assign load          = accept && (lane == LANE_Y2);

`ifdef VEC_PACK_TLAST_CHECK_EN
   logic frame_err_q;

   assign early_last = accept && s_axis.tlast && (lane != LANE_Y2);
   assign frame_err  = frame_err_q;

   // One-cycle error pulse following a truncated group
   always_ff @(posedge aclk) begin
      if (!aresetn) frame_err_q <= 1'b0;
      else          frame_err_q <= early_last;
   end
`else
   assign early_last = 1'b0;
   assign frame_err  = 1'b0;
`endif

   // Lane counter and collect register for x1, y1, x2
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         lane    <= LANE_X1;
         collect <= '0;
      end else if (accept) begin
         if (lane == LANE_Y2 || early_last) begin
            lane <= LANE_X1;
         end else begin
            lane <= lane_t'(lane + 2'd1);
            case (lane)
               LANE_X1: collect[3*CW-1:2*CW] <= s_axis.tdata;
               LANE_Y1: collect[2*CW-1:CW]   <= s_axis.tdata;
               default: collect[CW-1:0]      <= s_axis.tdata;
            endcase
         end
      end
   end

   vec_pack_out_reg #(
      .W (TW)
   ) u_out_reg (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .load      (load),
      .load_data ({collect, s_axis.tdata}),
      .load_last (s_axis.tlast),
      .out_ready (m_axis.tready),
      .out_valid (m_axis.tvalid),
      .out_data  (m_axis.tdata),
      .out_last  (m_axis.tlast),
      .can_load  (can_load)
   );

endmodule

// File: tb/tb_vec_mag_packer.sv
// tb_vec_mag_packer: randomized and directed bench for vec_mag_packer with a
// beat-list reference model and an expected-vector queue.
module tb_vec_mag_packer;

   localparam int CW = 8;
   localparam int TW = 4 * CW;

   logic clk;
   logic aresetn;
   logic frame_err;

   vec_mag_packer_if #(.W(CW)) s_if ();
   vec_mag_packer_if #(.W(TW)) m_if ();

   vec_mag_packer #(.COORD_WIDTH(CW)) dut (
      .aclk      (clk),
      .aresetn   (aresetn),
      .s_axis    (s_if),
      .m_axis    (m_if),
      .frame_err (frame_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- downstream ready driver ----------------
   int rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random
   initial m_if.tready = 1'b1;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_if.tready = 1'b1;
         1:       m_if.tready = 1'b0;
         default: m_if.tready = ($urandom_range(0, 2) != 0);
      endcase
   end

   // ---------------- reference model / scoreboard ----------------
   logic [CW-1:0] grp[$];      // beats of the group being assembled
   logic [TW:0]   exp_q[$];    // {last, data} of vectors owed downstream
   logic          exp_ferr = 1'b0;
   int            n_vec = 0;

   always @(negedge clk) begin
      if (!aresetn) begin
         grp.delete();
         exp_q.delete();
         exp_ferr = 1'b0;
      end else begin
         // a fourth beat can enter only if no vector is waiting unconsumed
         check("s_tready", s_if.tready,
               !(grp.size() == 3 && exp_q.size() != 0 && !m_if.tready));
         check("m_tvalid", m_if.tvalid, exp_q.size() != 0);
         check("frame_err", frame_err, exp_ferr);
         exp_ferr = 1'b0;
         if (m_if.tvalid && exp_q.size() != 0) begin
            check("m_tdata", m_if.tdata, exp_q[0][TW-1:0]);
            check("m_tlast", m_if.tlast, exp_q[0][TW]);
            if (m_if.tready) begin
               void'(exp_q.pop_front());
               n_vec++;
            end
         end
         if (s_if.tvalid && s_if.tready) begin
            grp.push_back(s_if.tdata);
            if (grp.size() == 4) begin
               exp_q.push_back({s_if.tlast, grp[0], grp[1], grp[2], grp[3]});
               grp.delete();
            end else if (s_if.tlast) begin
`ifdef VEC_PACK_TLAST_CHECK_EN
               grp.delete();
               exp_ferr = 1'b1;
`endif
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [CW-1:0] d, input logic l);
      bit done = 0;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (s_if.tready) done = 1;
         @(posedge clk);
         #1;
      end
      if (!done) check("beat_timeout", 0, 1);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      s_if.tvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      aresetn = 1'b0;
      @(posedge clk);
      #1;
      check("rst_tvalid", m_if.tvalid, 0);
      check("rst_tdata", m_if.tdata, 0);
      check("rst_tlast", m_if.tlast, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_sready", s_if.tready, 0);
      aresetn = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      aresetn     = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      apply_reset();

      // single vector with tlast on y2
      rdy_mode = 0;
      send_beat(8'h01, 0); send_beat(8'h02, 0);
      send_beat(8'h03, 0); send_beat(8'h04, 1);
      idle(3);
      check("first_vec_count", n_vec, 1);

      // 12 continuous beats
      for (int i = 0; i < 12; i++) send_beat(8'h10 + 8'(i), (i % 4) == 3);
      idle(3);
      check("cont_vec_count", n_vec, 4);

      // back-pressure: hold first vector, y2 of second group must stall
      rdy_mode = 1;
      idle(1);
      fork
         for (int i = 0; i < 12; i++) send_beat(8'h10 + 8'(i), 0);
         begin
            repeat (20) @(posedge clk);
            rdy_mode = 0;
         end
      join
      drain();
      check("bp_vec_count", n_vec, 7);

      // early tlast on the second beat
      send_beat(8'hAA, 0); send_beat(8'hBB, 1);
      send_beat(8'h01, 0); send_beat(8'h02, 0);
      send_beat(8'h03, 0); send_beat(8'h04, 1);
      idle(4);

      // reset mid-group
      apply_reset();   // clear any leftover lanes from the previous step
      send_beat(8'h05, 0); send_beat(8'h06, 0);
      apply_reset();
      send_beat(8'h07, 0); send_beat(8'h08, 0);
      send_beat(8'h09, 0); send_beat(8'h0A, 1);
      drain();

      // reset while a vector is held
      rdy_mode = 1;
      idle(1);
      send_beat(8'h21, 0); send_beat(8'h22, 0);
      send_beat(8'h23, 0); send_beat(8'h24, 1);
      idle(3);
      apply_reset();
      rdy_mode = 0;
      idle(6);

      // randomized traffic with random back-pressure and early tlast
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         send_beat(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      rdy_mode = 0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
